tlb_op_ctrl: RTL



---
 rtl/tlb_pkg.sv | 50 +++++
 rtl/tlb_op_ctrl_entry_match.sv | 14 +
 rtl/tlb_op_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/tlb_pkg.sv
// Shared types and field layout for the TLB operation sequencer and the
// entry matcher used by both the TLBP scan and the translation path.
package tlb_pkg;

    localparam int TLB_ENTRIES = 16;
    localparam int IDX_W       = 4;
    localparam int ENTRY_W     = 86;
    localparam int VPN2_W      = 19;
    localparam int ASID_W      = 8;

    // Packed entry: {VPN2, G, ASID, Lo0, Lo1}
    localparam int VPN2_MSB = 85;
    localparam int VPN2_LSB = 67;
    localparam int G_BIT    = 66;
    localparam int ASID_MSB = 65;
    localparam int ASID_LSB = 58;
    localparam int LO0_MSB  = 57;
    localparam int LO0_LSB  = 29;
    localparam int LO1_MSB  = 28;
    localparam int LO1_LSB  = 0;

    typedef enum logic [1:0] {
        OP_TLBP  = 2'b00,
        OP_TLBR  = 2'b01,
        OP_TLBWI = 2'b10,
        OP_TLBWR = 2'b11
    } tlb_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_RESP  = 3'd3,
        ST_SCAN  = 3'd4,
        ST_DONE  = 3'd5
    } tlb_state_e;

    function automatic logic [VPN2_W-1:0] entry_vpn2(input logic [ENTRY_W-1:0] e);
        return e[VPN2_MSB:VPN2_LSB];
    endfunction

    function automatic logic [ASID_W-1:0] entry_asid(input logic [ENTRY_W-1:0] e);
        return e[ASID_MSB:ASID_LSB];
    endfunction

    function automatic logic entry_g(input logic [ENTRY_W-1:0] e);
        return e[G_BIT];
    endfunction

endpackage

// File: rtl/tlb_op_ctrl_entry_match.sv
// Combinational VPN2/ASID compare of one TLB entry; a global entry ignores ASID.
module tlb_entry_match
    import tlb_pkg::*;
(
    input  logic [ENTRY_W-1:0] entry,
    input  logic [VPN2_W-1:0]  vpn2,
    input  logic [ASID_W-1:0]  asid,
    output logic               hit
);

    assign hit = (entry_vpn2(entry) == vpn2) &&
                 (entry_g(entry) || (entry_asid(entry) == asid));

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequencer for TLBP/TLBR/TLBWI/TLBWR against a 16-entry single-port TLB
// array with registered read; stalls the issuing instruction until done.
module tlb_op_ctrl
    import tlb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               op_valid,
    input  logic [1:0]         op_code,
    output logic               op_ready,
    output logic               op_done,
    input  logic               flush,
    input  logic [IDX_W-1:0]   cp0_index,
    input  logic [IDX_W-1:0]   cp0_random,
    input  logic [VPN2_W-1:0]  cp0_vpn2,
    input  logic [ASID_W-1:0]  cp0_asid,
    input  logic [ENTRY_W-1:0] cp0_conf,
    output logic [IDX_W-1:0]   tlb_raddr,
    input  logic [ENTRY_W-1:0] tlb_rdata,
    output logic               tlb_we,
    output logic [IDX_W-1:0]   tlb_waddr,
    output logic [ENTRY_W-1:0] tlb_wdata,
    output logic               probe_valid,
    output logic               probe_miss,
    output logic [IDX_W-1:0]   probe_index,
    output logic               conf_wen,
    output logic [ENTRY_W-1:0] conf_out,
    output tlb_state_e         dbg_state
);

    // Handshake: a request is taken on a cycle with op_valid && op_ready && !flush;
    // op_valid is held by the requester until then, and op_ready is high only in IDLE.

    tlb_state_e        state_q, state_d;
    tlb_op_e           op_q;
    logic [IDX_W-1:0]  raddr_q, waddr_q, cmp_idx_q, probe_index_q;
    logic [ENTRY_W-1:0] wdata_q, conf_q;
    logic [VPN2_W-1:0] vpn2_q;
    logic [ASID_W-1:0] asid_q;
    logic              cmp_valid_q, probe_miss_q;
    logic              accept, hit, scan_hit, scan_miss;

    tlb_entry_match u_match (
        .entry (tlb_rdata),
        .vpn2  (vpn2_q),
        .asid  (asid_q),
        .hit   (hit)
    );

    assign accept    = op_valid && (state_q == ST_IDLE) && !flush;
    // Read data lags the issued address by one cycle, so compares trail issues.
    assign scan_hit  = (state_q == ST_SCAN) && cmp_valid_q && hit;
    assign scan_miss = (state_q == ST_SCAN) && cmp_valid_q && !hit &&
                       (cmp_idx_q == IDX_W'(TLB_ENTRIES - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (tlb_op_e'(op_code))
                        OP_TLBP: state_d = ST_SCAN;
                        OP_TLBR: state_d = ST_READ;
                        default: state_d = ST_WRITE;
                    endcase
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_READ:  state_d = flush ? ST_IDLE : ST_RESP;
            ST_RESP:  state_d = flush ? ST_IDLE : ST_DONE;
            ST_SCAN: begin
                if (flush)
                    state_d = ST_IDLE;
                else if (scan_hit || scan_miss)
                    state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_TLBP;
            raddr_q       <= '0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            cmp_idx_q     <= '0;
            cmp_valid_q   <= 1'b0;
            vpn2_q        <= '0;
            asid_q        <= '0;
            conf_q        <= '0;
            probe_miss_q  <= 1'b0;
            probe_index_q <= '0;
        end else begin
            state_q <= state_d;

            if (accept) begin
                op_q          <= tlb_op_e'(op_code);
                vpn2_q        <= cp0_vpn2;
                asid_q        <= cp0_asid;
                cmp_valid_q   <= 1'b0;
                probe_miss_q  <= 1'b0;
                probe_index_q <= '0;
                raddr_q       <= (tlb_op_e'(op_code) == OP_TLBR) ? cp0_index : '0;
                if (op_code[1]) begin
                    waddr_q <= (tlb_op_e'(op_code) == OP_TLBWR) ? cp0_random : cp0_index;
                    wdata_q <= cp0_conf;
                end
            end

            if (state_q == ST_SCAN) begin
                if (raddr_q != IDX_W'(TLB_ENTRIES - 1))
                    raddr_q <= raddr_q + 1'b1;
                cmp_valid_q <= 1'b1;
                cmp_idx_q   <= raddr_q;
                if (scan_hit) begin
                    probe_miss_q  <= 1'b0;
                    probe_index_q <= cmp_idx_q;
                end else if (scan_miss) begin
                    probe_miss_q  <= 1'b1;
                    probe_index_q <= '0;
                end
            end

            if (state_q == ST_RESP)
                conf_q <= tlb_rdata;
        end
    end

    assign op_ready    = (state_q == ST_IDLE);
    assign op_done     = (state_q == ST_WRITE) || (state_q == ST_DONE);
    assign tlb_we      = (state_q == ST_WRITE);
    assign tlb_raddr   = raddr_q;
    assign tlb_waddr   = waddr_q;
    assign tlb_wdata   = wdata_q;
    assign probe_valid = (state_q == ST_DONE) && (op_q == OP_TLBP);
    assign probe_miss  = probe_miss_q;
    assign probe_index = probe_index_q;
    assign conf_wen    = (state_q == ST_DONE) && (op_q == OP_TLBR);
    assign conf_out    = conf_q;
    assign dbg_state   = state_q;

endmodule
